// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: PS/2 key + joystick merge with rotation and coin pulse stretching (optional SOCD_CLEAN_EN)
module arcade_input_mapper #(
    parameter int NBUTTONS   = 4,
    parameter int COIN_PULSE = 36000,
    parameter int JOY_SHARED = 1
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [10:0]         ps2_key,
    input  logic [15:0]         joystick_0,
    input  logic [15:0]         joystick_1,
    input  logic [1:0]          rotate,
    output logic [3:0]          p1_dir,
    output logic [NBUTTONS-1:0] p1_btn,
    output logic [3:0]          p2_dir,
    output logic [NBUTTONS-1:0] p2_btn,
    output logic [1:0]          start,
    output logic [1:0]          coin
);
    localparam int CW = $clog2(COIN_PULSE + 1);
    localparam logic [3:0][8:0] P1_DIR_CODES = {9'h175, 9'h172, 9'h16B, 9'h174};
    localparam logic [3:0][8:0] P2_DIR_CODES = {9'h02D, 9'h02B, 9'h023, 9'h034};
    localparam logic [3:0][8:0] P1_BTN_CODES = {9'h012, 9'h029, 9'h011, 9'h014};
    localparam logic [3:0][8:0] P2_BTN_CODES = {9'h01D, 9'h015, 9'h01B, 9'h01C};

    logic                old_toggle;
    logic [3:0]          p1_key_dir, p2_key_dir;
    logic [NBUTTONS-1:0] p1_key_btn, p2_key_btn;
    logic [1:0]          key_start, key_coin;
    logic [9:0]          j0_q, j1_q;
    logic [9:0]          joy_p1, joy_p2;
    logic [1:0]          start_src, coin_src, coin_prev;
    logic [CW-1:0]       cnt [2];
    logic                ev, pr;
    logic [8:0]          code;
    logic                unused_joy;

    assign unused_joy = ^{joystick_0[15:10], joystick_1[15:10]};
    assign ev         = ps2_key[10] != old_toggle;
    assign pr         = ps2_key[9];
    assign code       = ps2_key[8:0];
    assign joy_p1     = (JOY_SHARED != 0) ? (j0_q | j1_q) : j0_q;
    assign joy_p2     = (JOY_SHARED != 0) ? (j0_q | j1_q) : j1_q;
    assign start_src  = key_start | {joy_p2[8], joy_p1[8]};
    assign coin_src   = key_coin | {joy_p2[9], joy_p1[9]};
    assign coin       = {cnt[1] != '0, cnt[0] != '0};

    // maps raw {U,D,L,R} onto the screen orientation
    function automatic logic [3:0] rot(input logic [3:0] d, input logic [1:0] m);
        return (m == 2'd0) ? d :
               (m == 2'd1) ? {d[1], d[0], d[2], d[3]} :
               (m == 2'd2) ? {d[2], d[3], d[0], d[1]} :
                             {d[0], d[1], d[3], d[2]};
    endfunction

    // opposing directions cancel when cleaning is built in
    function automatic logic [3:0] socd(input logic [3:0] d);
`ifdef SOCD_CLEAN_EN
        return {d[3] & ~d[2], d[2] & ~d[3], d[1] & ~d[0], d[0] & ~d[1]};
`else
        return d;
`endif
    endfunction

    // stage 1: latch key states on toggle events and sample joysticks
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_toggle <= 1'b0;
            p1_key_dir <= '0;
            p2_key_dir <= '0;
            p1_key_btn <= '0;
            p2_key_btn <= '0;
            key_start  <= '0;
            key_coin   <= '0;
            j0_q       <= '0;
            j1_q       <= '0;
        end else begin
            old_toggle <= ps2_key[10];
            j0_q       <= joystick_0[9:0];
            j1_q       <= joystick_1[9:0];
            if (ev) begin
                for (int i = 0; i < 4; i++) begin
                    if (code == P1_DIR_CODES[i]) p1_key_dir[i] <= pr;
                    if (code == P2_DIR_CODES[i]) p2_key_dir[i] <= pr;
                end
                for (int i = 0; i < NBUTTONS; i++) begin
                    if (code == P1_BTN_CODES[i]) p1_key_btn[i] <= pr;
                    if (code == P2_BTN_CODES[i]) p2_key_btn[i] <= pr;
                end
                if (code == 9'h016 || code == 9'h005) key_start[0] <= pr;
                if (code == 9'h01E || code == 9'h006) key_start[1] <= pr;
                if (code == 9'h02E) key_coin[0] <= pr;
                if (code == 9'h036) key_coin[1] <= pr;
            end
        end
    end

    // stage 2: merge sources, rotate, clean and register player outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1_dir <= '0;
            p2_dir <= '0;
            p1_btn <= '0;
            p2_btn <= '0;
            start  <= '0;
        end else begin
            p1_dir <= socd(rot(p1_key_dir | joy_p1[3:0], rotate));
            p2_dir <= socd(rot(p2_key_dir | joy_p2[3:0], rotate));
            p1_btn <= p1_key_btn | joy_p1[4 +: NBUTTONS];
            p2_btn <= p2_key_btn | joy_p2[4 +: NBUTTONS];
            start  <= start_src;
        end
    end

    // coin stretchers: a rising source edge starts a pulse only when idle
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            coin_prev <= '0;
            cnt[0]    <= '0;
            cnt[1]    <= '0;
        end else begin
            coin_prev <= coin_src;
            for (int n = 0; n < 2; n++) begin
                if (cnt[n] != '0) cnt[n] <= cnt[n] - CW'(1);
                else if (coin_src[n] && !coin_prev[n]) cnt[n] <= CW'(COIN_PULSE);
            end
        end
    end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed checks of shared and split joystick builds
module tb_arcade_input_mapper;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [15:0] joystick_0 = '0;
    logic [15:0] joystick_1 = '0;
    logic [1:0]  rotate = '0;
    logic [3:0]  sh_p1_dir, sh_p2_dir, ns_p1_dir, ns_p2_dir;
    logic [3:0]  sh_p1_btn, sh_p2_btn, ns_p1_btn, ns_p2_btn;
    logic [1:0]  sh_start, sh_coin, ns_start, ns_coin;
    logic        tog = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(.NBUTTONS(4), .COIN_PULSE(10), .JOY_SHARED(1)) u_sh (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate),
        .p1_dir(sh_p1_dir), .p1_btn(sh_p1_btn), .p2_dir(sh_p2_dir), .p2_btn(sh_p2_btn),
        .start(sh_start), .coin(sh_coin)
    );

    arcade_input_mapper #(.NBUTTONS(4), .COIN_PULSE(10), .JOY_SHARED(0)) u_ns (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate),
        .p1_dir(ns_p1_dir), .p1_btn(ns_p1_btn), .p2_dir(ns_p2_dir), .p2_btn(ns_p2_btn),
        .start(ns_start), .coin(ns_coin)
    );

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic key_event(input logic [8:0] code, input logic pressed);
        tog = ~tog;
        ps2_key = {tog, pressed, code};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        joystick_0 = 16'hFFFF;
        repeat (3) step();
        checks++;
        if (sh_p1_dir !== 4'h0 || sh_start !== 2'b00 || sh_coin !== 2'b00 || ns_p2_btn !== 4'h0) begin
            failures++;
            $display("FAIL reset_hold: p1_dir=%b start=%b coin=%b p2_btn=%b expected all 0", sh_p1_dir, sh_start, sh_coin, ns_p2_btn);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (sh_p1_dir !== 4'h0 || sh_coin !== 2'b00) begin
            failures++;
            $display("FAIL reset_edge1: p1_dir=%b coin=%b expected 0000 00", sh_p1_dir, sh_coin);
        end
        step();
        checks++;
        if (sh_p1_dir !== 4'b1111 || sh_start !== 2'b11) begin
            failures++;
            $display("FAIL reset_edge2: p1_dir=%b start=%b expected 1111 11", sh_p1_dir, sh_start);
        end
        checks++;
        if (ns_start !== 2'b01 || ns_p2_dir !== 4'b0000) begin
            failures++;
            $display("FAIL reset_split: start=%b p2_dir=%b expected 01 0000", ns_start, ns_p2_dir);
        end
        checks++;
        if (sh_coin !== 2'b11 || ns_coin !== 2'b01) begin
            failures++;
            $display("FAIL reset_coin: shared=%b split=%b expected 11 01", sh_coin, ns_coin);
        end
        joystick_0 = 16'h0000;
        repeat (14) step();
        checks++;
        if (sh_coin !== 2'b00 || sh_p1_dir !== 4'h0 || sh_start !== 2'b00) begin
            failures++;
            $display("FAIL reset_drain: coin=%b p1_dir=%b start=%b expected 00 0000 00", sh_coin, sh_p1_dir, sh_start);
        end
    endtask

    task automatic test_key_latch();
        key_event(9'h175, 1'b1);
        step();
        checks++;
        if (sh_p1_dir !== 4'b0000) begin
            failures++;
            $display("FAIL key_latency: p1_dir=%b expected 0000", sh_p1_dir);
        end
        step();
        checks++;
        if (sh_p1_dir !== 4'b1000) begin
            failures++;
            $display("FAIL key_press: p1_dir=%b expected 1000", sh_p1_dir);
        end
        repeat (3) step();
        checks++;
        if (sh_p1_dir !== 4'b1000) begin
            failures++;
            $display("FAIL key_hold: p1_dir=%b expected 1000", sh_p1_dir);
        end
        key_event(9'h175, 1'b0);
        repeat (2) step();
        checks++;
        if (sh_p1_dir !== 4'b0000) begin
            failures++;
            $display("FAIL key_release: p1_dir=%b expected 0000", sh_p1_dir);
        end
        ps2_key = {tog, 1'b1, 9'h175};
        repeat (3) step();
        checks++;
        if (sh_p1_dir !== 4'b0000) begin
            failures++;
            $display("FAIL key_no_toggle: p1_dir=%b expected 0000", sh_p1_dir);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_rot [4];
        exp_rot = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
        key_event(9'h175, 1'b1);
        repeat (2) step();
        for (int m = 0; m < 4; m++) begin
            rotate = 2'(m);
            step();
            checks++;
            if (sh_p1_dir !== exp_rot[m] || ns_p1_dir !== exp_rot[m]) begin
                failures++;
                $display("FAIL rotate_%0d: shared=%b split=%b expected %b", m, sh_p1_dir, ns_p1_dir, exp_rot[m]);
            end
        end
        rotate = 2'd0;
        key_event(9'h175, 1'b0);
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        key_event(9'h02D, 1'b1);
        step();
        key_event(9'h01C, 1'b1);
        step();
        key_event(9'h016, 1'b1);
        step();
        step();
        checks++;
        if (sh_p2_dir !== 4'b1000 || sh_p2_btn !== 4'b0001 || sh_p1_dir !== 4'b0000 || sh_start !== 2'b01) begin
            failures++;
            $display("FAIL back_to_back: p2_dir=%b p2_btn=%b p1_dir=%b start=%b expected 1000 0001 0000 01", sh_p2_dir, sh_p2_btn, sh_p1_dir, sh_start);
        end
        key_event(9'h02D, 1'b0);
        step();
        key_event(9'h01C, 1'b0);
        step();
        key_event(9'h016, 1'b0);
        repeat (2) step();
        key_event(9'h0AA, 1'b1);
        repeat (2) step();
        checks++;
        if (sh_p1_dir !== 4'h0 || sh_p2_dir !== 4'h0 || sh_p1_btn !== 4'h0 || sh_p2_btn !== 4'h0 || sh_start !== 2'b00) begin
            failures++;
            $display("FAIL unmatched_code: p1_dir=%b p2_dir=%b p1_btn=%b p2_btn=%b start=%b expected all 0", sh_p1_dir, sh_p2_dir, sh_p1_btn, sh_p2_btn, sh_start);
        end
    endtask

    task automatic test_coin();
        logic exp_c;
        for (int c = 0; c <= 30; c++) begin
            if (c == 0 || c == 5 || c == 12) key_event(9'h02E, 1'b1);
            if (c == 3 || c == 8 || c == 15) key_event(9'h02E, 1'b0);
            step();
            exp_c = (c >= 1 && c <= 10) || (c >= 13 && c <= 22);
            checks++;
            if (sh_coin !== {1'b0, exp_c}) begin
                failures++;
                $display("FAIL coin_cycle_%0d: coin=%b expected %b", c, sh_coin, {1'b0, exp_c});
            end
        end
    endtask

    task automatic test_routing();
        joystick_1 = 16'h0010;
        repeat (2) step();
        checks++;
        if (sh_p1_btn !== 4'b0001 || sh_p2_btn !== 4'b0001) begin
            failures++;
            $display("FAIL routing_shared: p1_btn=%b p2_btn=%b expected 0001 0001", sh_p1_btn, sh_p2_btn);
        end
        checks++;
        if (ns_p1_btn !== 4'b0000 || ns_p2_btn !== 4'b0001) begin
            failures++;
            $display("FAIL routing_split: p1_btn=%b p2_btn=%b expected 0000 0001", ns_p1_btn, ns_p2_btn);
        end
        joystick_1 = 16'h0000;
        repeat (2) step();
    endtask

    task automatic test_socd();
        logic [3:0] exp_d;
`ifdef SOCD_CLEAN_EN
        exp_d = 4'b0001;
`else
        exp_d = 4'b1101;
`endif
        key_event(9'h175, 1'b1);
        step();
        key_event(9'h172, 1'b1);
        step();
        joystick_0 = 16'h0001;
        repeat (2) step();
        checks++;
        if (sh_p1_dir !== exp_d || ns_p1_dir !== exp_d) begin
            failures++;
            $display("FAIL socd: shared=%b split=%b expected %b", sh_p1_dir, ns_p1_dir, exp_d);
        end
        joystick_0 = 16'h0000;
        key_event(9'h175, 1'b0);
        step();
        key_event(9'h172, 1'b0);
        repeat (2) step();
        checks++;
        if (sh_p1_dir !== 4'b0000) begin
            failures++;
            $display("FAIL socd_release: p1_dir=%b expected 0000", sh_p1_dir);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_key_latch();
        test_rotation();
        test_back_to_back();
        test_coin();
        test_routing();
        test_socd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
